alu_issue_stage: RTL

//  Instruction issue/writeback stage wrapped around the 16-bit combinational ALU.
//  - Accepts 16-bit instruction words on a valid/ready handshake.
//  - Reads two operands from an internal 8x16 register file and drives the ALU A/B/ALU_Sel.
//  - Writes the ALU result and carry back on the following edge.
//  - Sits directly upstream of the ALU and also consumes its ALU_Out/CarryOut.

---
 rtl/alu_issue_pkg.sv | 34 +++
 rtl/alu_regfile.sv | 39 +++
 rtl/alu_issue_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and instruction field positions for the ALU issue stage.
package alu_issue_pkg;

  localparam int unsigned OpMsb  = 15;
  localparam int unsigned OpLsb  = 12;
  localparam int unsigned RdMsb  = 11;
  localparam int unsigned RdLsb  = 9;
  localparam int unsigned Rs1Msb = 8;
  localparam int unsigned Rs1Lsb = 6;
  localparam int unsigned Rs2Msb = 5;
  localparam int unsigned Rs2Lsb = 3;
  localparam int unsigned ImmMsb = 8;
  localparam int unsigned ImmW   = 9;

  // Opcodes 9..14 have no name; the ALU's default case makes them a MOV.
  typedef enum logic [3:0] {
    ADD  = 4'h0,
    SUB  = 4'h1,
    AND  = 4'h2,
    OR   = 4'h3,
    XOR  = 4'h4,
    NOTA = 4'h5,
    NOTB = 4'h6,
    SHL  = 4'h7,
    SHR  = 4'h8,
    LDI  = 4'hF
  } op_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: async clear, one write port, two operand read ports
// (sampled by the issue logic at accept) and one combinational debug port.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [2:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [2:0]        raddr1_i,
  input  logic [2:0]        raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic [2:0]        dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] rf_q [NREGS];

  // Storage: cleared on reset, single write per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = rf_q[raddr1_i];
  assign rdata2_o   = rf_q[raddr2_i];
  assign dbg_data_o = rf_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of a 16-bit combinational ALU. Accepts one
// instruction per two cycles, drives registered ALU operands, writes back the
// ALU result (or an LDI immediate) on the following edge.
// Optional: define ALU_ISSUE_FLAGS_EN to add zero_flag/neg_flag outputs.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              wb_valid,
  output logic              carry_flag,
`ifdef ALU_ISSUE_FLAGS_EN
  output logic              zero_flag,
  output logic              neg_flag,
`endif
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [3:0]        alu_sel_q;
  logic [2:0]        rd_q;
  logic [ImmW-1:0]   imm_q;
  logic              carry_q;
  logic              accept;
  logic              rf_we;
  logic              alu_class_wb;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic [2:0]        unused_instr;

  assign unused_instr = instr[2:0];

  assign instr_ready  = (state_q == IDLE);
  assign wb_valid     = (state_q == EXEC);
  assign accept       = instr_valid & instr_ready;
  assign alu_class_wb = wb_valid & (alu_sel_q != LDI);

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (rf_wdata),
    .raddr1_i   (instr[Rs1Msb:Rs1Lsb]),
    .raddr2_i   (instr[Rs2Msb:Rs2Lsb]),
    .rdata1_o   (rs1_data),
    .rdata2_o   (rs2_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // Next state and writeback selection.
  always_comb begin
    state_d  = state_q;
    rf_we    = 1'b0;
    rf_wdata = alu_result;
    case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        state_d = IDLE;
        rf_we   = 1'b1;
        if (alu_sel_q == LDI) rf_wdata = {{(DATA_W-ImmW){1'b0}}, imm_q};
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand capture at accept, sticky carry on ALU-class writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a_q   <= rs1_data;
        alu_b_q   <= rs2_data;
        alu_sel_q <= instr[OpMsb:OpLsb];
        rd_q      <= instr[RdMsb:RdLsb];
        imm_q     <= instr[ImmMsb:0];
      end
      if (alu_class_wb) carry_q <= alu_carry;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign carry_flag = carry_q;

`ifdef ALU_ISSUE_FLAGS_EN
  logic zero_q, neg_q;

  // Result flags track carry_flag: only ALU-class writebacks update them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (alu_class_wb) begin
      zero_q <= (alu_result == '0);
      neg_q  <= alu_result[DATA_W-1];
    end
  end

  assign zero_flag = zero_q;
  assign neg_flag  = neg_q;
`endif

endmodule
